// File: rtl/mic_sched_pkg.sv
// Shared types, defaults and helpers for the mic FIR frame scheduler.
package mic_sched_pkg;

  typedef enum logic {
    COLLECT,
    ISSUE
  } state_e;

  localparam int unsigned DEF_NUM_CH = 3;
  localparam int unsigned DEF_WIDTH  = 16;
  localparam int unsigned STAT_W     = 16;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/mic_frame_demux.sv
// Demultiplexes the interleaved FIR output stream into per-channel held outputs,
// keeping one frame in every DECIM and resynchronising on tlast misalignment.
module mic_frame_demux
  import mic_sched_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned DECIM  = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [WIDTH-1:0]        tdata_i,
  input  logic                    tvalid_i,
  input  logic                    tlast_i,
  output logic [NUM_CH*WIDTH-1:0] ch_data_o,
  output logic [NUM_CH-1:0]       ch_valid_o,
  output logic                    sync_err_o
);

  localparam int unsigned   IW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned   DW       = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CH - 1);
  localparam logic [DW-1:0] LAST_DEC = DW'(DECIM - 1);

  logic [IW-1:0]           out_idx_q, out_idx_d;
  logic [DW-1:0]           dec_q, dec_d;
  logic [NUM_CH*WIDTH-1:0] ch_data_q, ch_data_d;
  logic [NUM_CH-1:0]       ch_valid_q, ch_valid_d;
  logic                    at_last;

  assign at_last = (out_idx_q == LAST_IDX);

  always_comb begin
    out_idx_d  = out_idx_q;
    dec_d      = dec_q;
    ch_data_d  = ch_data_q;
    ch_valid_d = '0;
    sync_err_o = 1'b0;
    if (tvalid_i) begin
      if (tlast_i != at_last) begin
        // Misaligned beat is discarded; the next beat is treated as channel 0 of a kept frame
        sync_err_o = 1'b1;
        out_idx_d  = '0;
        dec_d      = '0;
      end else begin
        if (dec_q == '0) begin
          for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (out_idx_q == IW'(k)) begin
              ch_data_d[k*WIDTH +: WIDTH] = tdata_i;
              ch_valid_d[k]               = 1'b1;
            end
          end
        end
        if (at_last) begin
          out_idx_d = '0;
          dec_d     = (dec_q == LAST_DEC) ? '0 : dec_q + DW'(1);
        end else begin
          out_idx_d = out_idx_q + IW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_idx_q  <= '0;
      dec_q      <= '0;
      ch_data_q  <= '0;
      ch_valid_q <= '0;
    end else begin
      out_idx_q  <= out_idx_d;
      dec_q      <= dec_d;
      ch_data_q  <= ch_data_d;
      ch_valid_q <= ch_valid_d;
    end
  end

  assign ch_data_o  = ch_data_q;
  assign ch_valid_o = ch_valid_q;

endmodule

// File: rtl/mic_fir_scheduler.sv
// Shares one interleaved FIR between the mic front-ends: frame capture, issue, demux.
// Statistics counters are built only when MIC_FIR_SCHED_STATS_EN is defined.
module mic_fir_scheduler
  import mic_sched_pkg::*;
#(
  parameter int unsigned NUM_CH   = DEF_NUM_CH,
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned DECIM    = 2,
  parameter int unsigned SKEW_MAX = 64
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [NUM_CH*WIDTH-1:0] sample_in,
  input  logic [NUM_CH-1:0]       sample_valid_in,
  output logic [WIDTH-1:0]        fir_tdata_out,
  output logic                    fir_tvalid_out,
  output logic                    fir_tlast_out,
  input  logic                    fir_tready_in,
  input  logic [WIDTH-1:0]        fir_tdata_in,
  input  logic                    fir_tvalid_in,
  input  logic                    fir_tlast_in,
  output logic [NUM_CH*WIDTH-1:0] ch_data_out,
  output logic [NUM_CH-1:0]       ch_valid_out,
  output logic                    overrun_out,
  output logic                    stale_out,
  output logic                    sync_err_out,
  output logic [STAT_W-1:0]       overrun_cnt_out,
  output logic [STAT_W-1:0]       stale_cnt_out,
  output logic [STAT_W-1:0]       sync_err_cnt_out
);

  localparam int unsigned   IW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned   SW       = $clog2(SKEW_MAX + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CH - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  hold_q [NUM_CH];
  logic [WIDTH-1:0]  hold_d [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d, consume, ovr_vec;
  logic [IW-1:0]     idx_q, idx_d, nxt_idx;
  logic [SW-1:0]     skew_q, skew_d;
  logic [WIDTH-1:0]  tdata_q, tdata_d, nxt_data;
  logic              tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic              handshake, last_beat, all_pend, any_pend, skew_done;
  logic              stale_evt, sync_evt;
  logic              overrun_q, stale_q, sync_q;

  assign handshake = tvalid_q & fir_tready_in;
  assign last_beat = handshake & (idx_q == LAST_IDX);
  assign all_pend  = &pend_q;
  assign any_pend  = |pend_q;
  assign skew_done = (skew_q == SW'(SKEW_MAX));
  assign nxt_idx   = idx_q + IW'(1);

  // A strobe landing on the cycle its channel is consumed re-arms pending for the next frame
  always_comb begin
    consume = '0;
    ovr_vec = '0;
    pend_d  = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      consume[k] = handshake & (idx_q == IW'(k));
      hold_d[k]  = sample_valid_in[k] ? sample_in[k*WIDTH +: WIDTH] : hold_q[k];
      pend_d[k]  = sample_valid_in[k] | (pend_q[k] & ~consume[k]);
      ovr_vec[k] = sample_valid_in[k] & pend_q[k] & ~consume[k];
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pend_q <= '0;
      for (int unsigned k = 0; k < NUM_CH; k++) hold_q[k] <= '0;
    end else begin
      pend_q <= pend_d;
      for (int unsigned k = 0; k < NUM_CH; k++) hold_q[k] <= hold_d[k];
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= COLLECT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (all_pend || (any_pend && skew_done)) state_d = ISSUE;
      ISSUE:   if (last_beat) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // Beat data is taken from the next-state hold so a same-cycle strobe is not missed
  always_comb begin
    nxt_data = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (nxt_idx == IW'(k)) nxt_data = hold_d[k];
    end
    tvalid_d  = tvalid_q;
    tdata_d   = tdata_q;
    tlast_d   = tlast_q;
    idx_d     = idx_q;
    skew_d    = skew_q;
    stale_evt = 1'b0;
    case (state_q)
      COLLECT: begin
        if (state_d == ISSUE) begin
          tvalid_d  = 1'b1;
          tdata_d   = hold_d[0];
          tlast_d   = (NUM_CH == 1);
          idx_d     = '0;
          skew_d    = '0;
          stale_evt = ~all_pend;
        end else if (any_pend) begin
          skew_d = skew_q + SW'(1);
        end
      end
      ISSUE: begin
        if (handshake) begin
          if (idx_q == LAST_IDX) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            idx_d    = '0;
            skew_d   = '0;
          end else begin
            idx_d   = nxt_idx;
            tdata_d = nxt_data;
            tlast_d = (nxt_idx == LAST_IDX);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      idx_q    <= '0;
      skew_q   <= '0;
    end else begin
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      idx_q    <= idx_d;
      skew_q   <= skew_d;
    end
  end

  assign fir_tvalid_out = tvalid_q;
  assign fir_tdata_out  = tdata_q;
  assign fir_tlast_out  = tlast_q;

  mic_frame_demux #(
    .NUM_CH (NUM_CH),
    .WIDTH  (WIDTH),
    .DECIM  (DECIM)
  ) u_demux (
    .clk_i      (clk_in),
    .rst_i      (rst_in),
    .tdata_i    (fir_tdata_in),
    .tvalid_i   (fir_tvalid_in),
    .tlast_i    (fir_tlast_in),
    .ch_data_o  (ch_data_out),
    .ch_valid_o (ch_valid_out),
    .sync_err_o (sync_evt)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      overrun_q <= 1'b0;
      stale_q   <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      overrun_q <= overrun_q | (|ovr_vec);
      stale_q   <= stale_q | stale_evt;
      sync_q    <= sync_q | sync_evt;
    end
  end

  assign overrun_out  = overrun_q;
  assign stale_out    = stale_q;
  assign sync_err_out = sync_q;

`ifdef MIC_FIR_SCHED_STATS_EN
  logic [STAT_W-1:0] ovr_cnt_q, stale_cnt_q, sync_cnt_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ovr_cnt_q   <= '0;
      stale_cnt_q <= '0;
      sync_cnt_q  <= '0;
    end else begin
      if (|ovr_vec)  ovr_cnt_q   <= sat_inc(ovr_cnt_q);
      if (stale_evt) stale_cnt_q <= sat_inc(stale_cnt_q);
      if (sync_evt)  sync_cnt_q  <= sat_inc(sync_cnt_q);
    end
  end

  assign overrun_cnt_out  = ovr_cnt_q;
  assign stale_cnt_out    = stale_cnt_q;
  assign sync_err_cnt_out = sync_cnt_q;
`else
  assign overrun_cnt_out  = '0;
  assign stale_cnt_out    = '0;
  assign sync_err_cnt_out = '0;
`endif

endmodule

// File: tb/tb_mic_fir_scheduler.sv
// Directed self-checking bench for mic_fir_scheduler (either stats build).
module tb_mic_fir_scheduler;

  localparam int unsigned NUM_CH   = 3;
  localparam int unsigned WIDTH    = 16;
  localparam int unsigned DECIM    = 2;
  localparam int unsigned SKEW_MAX = 64;

`ifdef MIC_FIR_SCHED_STATS_EN
  localparam logic [15:0] CNT1 = 16'd1;
`else
  localparam logic [15:0] CNT1 = 16'd0;
`endif

  logic                    clk_in;
  logic                    rst_in;
  logic [NUM_CH*WIDTH-1:0] sample_in;
  logic [NUM_CH-1:0]       sample_valid_in;
  logic [WIDTH-1:0]        fir_tdata_out;
  logic                    fir_tvalid_out;
  logic                    fir_tlast_out;
  logic                    fir_tready_in;
  logic [WIDTH-1:0]        fir_tdata_in;
  logic                    fir_tvalid_in;
  logic                    fir_tlast_in;
  logic [NUM_CH*WIDTH-1:0] ch_data_out;
  logic [NUM_CH-1:0]       ch_valid_out;
  logic                    overrun_out, stale_out, sync_err_out;
  logic [15:0]             overrun_cnt_out, stale_cnt_out, sync_err_cnt_out;

  int n_checks = 0;
  int n_errors = 0;
  int hs_cnt   = 0;

  logic             lb_en, man_v, man_l;
  logic [WIDTH-1:0] man_d;
  logic [3:0]       pv, pl;
  logic [3:0][WIDTH-1:0] pd;

  mic_fir_scheduler #(
    .NUM_CH   (NUM_CH),
    .WIDTH    (WIDTH),
    .DECIM    (DECIM),
    .SKEW_MAX (SKEW_MAX)
  ) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .sample_in        (sample_in),
    .sample_valid_in  (sample_valid_in),
    .fir_tdata_out    (fir_tdata_out),
    .fir_tvalid_out   (fir_tvalid_out),
    .fir_tlast_out    (fir_tlast_out),
    .fir_tready_in    (fir_tready_in),
    .fir_tdata_in     (fir_tdata_in),
    .fir_tvalid_in    (fir_tvalid_in),
    .fir_tlast_in     (fir_tlast_in),
    .ch_data_out      (ch_data_out),
    .ch_valid_out     (ch_valid_out),
    .overrun_out      (overrun_out),
    .stale_out        (stale_out),
    .sync_err_out     (sync_err_out),
    .overrun_cnt_out  (overrun_cnt_out),
    .stale_cnt_out    (stale_cnt_out),
    .sync_err_cnt_out (sync_err_cnt_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Loopback FIR: echoes accepted beats four cycles later with their tlast
  always @(posedge clk_in) begin
    pv <= {pv[2:0], fir_tvalid_out & fir_tready_in};
    pl <= {pl[2:0], fir_tlast_out};
    pd <= {pd[2:0], fir_tdata_out};
    if (fir_tvalid_out && fir_tready_in) hs_cnt <= hs_cnt + 1;
  end

  assign fir_tvalid_in = lb_en ? pv[3] : man_v;
  assign fir_tlast_in  = lb_en ? pl[3] : man_l;
  assign fir_tdata_in  = lb_en ? pd[3] : man_d;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [15:0] d, input logic l);
    check({tag, "_v"}, 64'(fir_tvalid_out), 64'd1);
    check({tag, "_d"}, 64'(fir_tdata_out), 64'(d));
    check({tag, "_l"}, 64'(fir_tlast_out), 64'(l));
  endtask

  task automatic do_reset();
    sample_valid_in = '0;
    man_v           = 1'b0;
    lb_en           = 1'b0;
    repeat (6) @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in        = 1'b0;
    fir_tready_in = 1'b1;
  endtask

  function automatic logic [15:0] lb_val(input int f, input int k);
    return 16'((f + 1) * 4096 + k + 1);
  endfunction

  int               found;
  int               pcnt [4][3];
  logic [15:0]      gdat [4][3];
  int               hs0;

  initial begin
    rst_in          = 1'b1;
    sample_in       = '0;
    sample_valid_in = '0;
    fir_tready_in   = 1'b0;
    man_v = 1'b0; man_l = 1'b0; man_d = '0; lb_en = 1'b0;
    for (int f = 0; f < 4; f++)
      for (int k = 0; k < 3; k++) begin
        pcnt[f][k] = 0;
        gdat[f][k] = '0;
      end
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);

    check("rst_tvalid",  64'(fir_tvalid_out), 64'd0);
    check("rst_chvalid", 64'(ch_valid_out), 64'd0);
    check("rst_chdata",  64'(ch_data_out), 64'd0);
    check("rst_flags",   64'({overrun_out, stale_out, sync_err_out}), 64'd0);
    check("rst_cnts",    64'({overrun_cnt_out, stale_cnt_out, sync_err_cnt_out}), 64'd0);

    // Full frame: strobe at edge 1, pending at 1, tvalid from edge 2
    fir_tready_in   = 1'b1;
    sample_in       = {16'h0300, 16'h0200, 16'h0100};
    sample_valid_in = 3'b111;
    @(negedge clk_in);
    sample_valid_in = '0;
    check("t1_latency", 64'(fir_tvalid_out), 64'd0);
    @(negedge clk_in); chk_beat("t1_b0", 16'h0100, 1'b0);
    @(negedge clk_in); chk_beat("t1_b1", 16'h0200, 1'b0);
    @(negedge clk_in); chk_beat("t1_b2", 16'h0300, 1'b1);
    @(negedge clk_in);
    check("t1_idle", 64'(fir_tvalid_out), 64'd0);
    check("t1_flags", 64'({overrun_out, stale_out, sync_err_out}), 64'd0);

    // Skew timeout: pending from edge 1, counter hits 64 at edge 65, issue at edge 66
    sample_in       = {16'h0000, 16'h0B0B, 16'h0A0A};
    sample_valid_in = 3'b011;
    found = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk_in);
      sample_valid_in = '0;
      if (fir_tvalid_out) begin
        found = k;
        break;
      end
    end
    check("t2_issue_cycle", 64'(found), 64'd66);
    chk_beat("t2_b0", 16'h0A0A, 1'b0);
    @(negedge clk_in); chk_beat("t2_b1", 16'h0B0B, 1'b0);
    @(negedge clk_in); chk_beat("t2_b2", 16'h0300, 1'b1);
    @(negedge clk_in);
    check("t2_idle", 64'(fir_tvalid_out), 64'd0);
    @(negedge clk_in);
    sample_in       = {16'h0C0C, 16'h0B0B, 16'h0A0A};
    sample_valid_in = 3'b100;
    @(negedge clk_in);
    sample_valid_in = '0;
    check("t2_stale", 64'(stale_out), 64'd1);
    check("t2_stale_cnt", 64'(stale_cnt_out), 64'(CNT1));
    check("t2_no_overrun", 64'(overrun_out), 64'd0);

    // Overrun on channel 1 before the frame completes
    do_reset();
    sample_in       = {16'h0000, 16'h1111, 16'h0000};
    sample_valid_in = 3'b010;
    @(negedge clk_in);
    sample_valid_in = '0;
    @(negedge clk_in);
    sample_in       = {16'h0000, 16'h2222, 16'h0000};
    sample_valid_in = 3'b010;
    @(negedge clk_in);
    sample_in       = {16'h00CC, 16'h2222, 16'h00AA};
    sample_valid_in = 3'b101;
    @(negedge clk_in);
    sample_valid_in = '0;
    check("t3_latency", 64'(fir_tvalid_out), 64'd0);
    @(negedge clk_in); chk_beat("t3_b0", 16'h00AA, 1'b0);
    @(negedge clk_in); chk_beat("t3_b1", 16'h2222, 1'b0);
    @(negedge clk_in); chk_beat("t3_b2", 16'h00CC, 1'b1);
    @(negedge clk_in);
    check("t3_overrun", 64'(overrun_out), 64'd1);
    check("t3_overrun_cnt", 64'(overrun_cnt_out), 64'(CNT1));
    check("t3_no_stale", 64'(stale_out), 64'd0);

    // Backpressure: ready low for five edges while beat 1 is presented
    do_reset();
    hs0 = hs_cnt;
    sample_in       = {16'h0333, 16'h0222, 16'h0111};
    sample_valid_in = 3'b111;
    @(negedge clk_in);
    sample_valid_in = '0;
    @(negedge clk_in); chk_beat("t4_b0", 16'h0111, 1'b0);
    @(negedge clk_in); chk_beat("t4_b1", 16'h0222, 1'b0);
    fir_tready_in = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_in);
      chk_beat($sformatf("t4_hold%0d", c), 16'h0222, 1'b0);
    end
    fir_tready_in = 1'b1;
    @(negedge clk_in); chk_beat("t4_b2", 16'h0333, 1'b1);
    @(negedge clk_in);
    check("t4_idle", 64'(fir_tvalid_out), 64'd0);
    check("t4_handshakes", 64'(hs_cnt - hs0), 64'd3);

    // Loopback with DECIM=2: frames 0 and 2 reach the outputs, 1 and 3 do not
    do_reset();
    lb_en = 1'b1;
    for (int f = 0; f < 4; f++) begin
      sample_in       = {lb_val(f, 2), lb_val(f, 1), lb_val(f, 0)};
      sample_valid_in = 3'b111;
      for (int w = 1; w <= 14; w++) begin
        @(negedge clk_in);
        sample_valid_in = '0;
        for (int k = 0; k < 3; k++) begin
          if (ch_valid_out[k]) begin
            pcnt[f][k] = pcnt[f][k] + 1;
            gdat[f][k] = ch_data_out[k*WIDTH +: WIDTH];
          end
        end
      end
    end
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("t5_f%0d_c%0d_pulses", f, k), 64'(pcnt[f][k]), (f % 2 == 0) ? 64'd1 : 64'd0);
        if (f % 2 == 0)
          check($sformatf("t5_f%0d_c%0d_data", f, k), 64'(gdat[f][k]), 64'(lb_val(f, k)));
      end
    end
    check("t5_held", 64'(ch_data_out), 64'({lb_val(2, 2), lb_val(2, 1), lb_val(2, 0)}));
    check("t5_no_sync_err", 64'(sync_err_out), 64'd0);
    lb_en = 1'b0;

    // Sync error: tlast on out_idx=1 drops that sample and realigns to channel 0
    do_reset();
    man_d = 16'h0AAA; man_l = 1'b0; man_v = 1'b1;
    @(negedge clk_in);
    check("t6_a_valid", 64'(ch_valid_out), 64'd1);
    check("t6_a_data", 64'(ch_data_out[15:0]), 64'h0AAA);
    man_d = 16'h0BBB; man_l = 1'b1;
    @(negedge clk_in);
    check("t6_b_dropped", 64'(ch_valid_out), 64'd0);
    check("t6_b_ch1", 64'(ch_data_out[31:16]), 64'd0);
    check("t6_sync_err", 64'(sync_err_out), 64'd1);
    man_d = 16'h0CCC; man_l = 1'b0;
    @(negedge clk_in);
    man_v = 1'b0;
    check("t6_c_valid", 64'(ch_valid_out), 64'd1);
    check("t6_c_data", 64'(ch_data_out[15:0]), 64'h0CCC);
    @(negedge clk_in);
    check("t6_sync_cnt", 64'(sync_err_cnt_out), 64'(CNT1));
    check("t6_sticky", 64'(sync_err_out), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mic_fir_scheduler.md
# mic_fir_scheduler

Frame scheduler that shares one interleaved multichannel anti-alias FIR between the three I2S microphone front-ends. Collects one sample per mic into a frame, issues the frame to the FIR in fixed channel order over an AXI-stream-style handshake, then demultiplexes and decimates the filtered stream back into per-mic outputs. Sits between the `i2s` instances and the per-mic downsampled audio consumers (PDM monitor, speed-of-sound calculator).

## Interface
- NUM_CH, 3: number of mic channels; also the FIR's configured channel count.
- WIDTH, 16: sample width, signed.
- DECIM, 2: output decimation factor; 1 = no decimation.
- SKEW_MAX, 64: cycles allowed between a frame's first and last arriving sample.
- clk_in  input  1  audio clock (98.3 MHz).
- rst_in  input  1  asynchronous, active-high reset.
- sample_in  input  NUM_CH*WIDTH  raw mic samples; channel k at [k*WIDTH +: WIDTH].
- sample_valid_in  input  NUM_CH  one-cycle strobe per channel (the i2s data_valid_out).
- fir_tdata_out  output  WIDTH  sample to FIR.
- fir_tvalid_out  output  1  FIR input valid.
- fir_tlast_out  output  1  high on channel NUM_CH-1 beat.
- fir_tready_in  input  1  FIR input ready.
- fir_tdata_in  input  WIDTH  filtered sample from FIR.
- fir_tvalid_in  input  1  filtered sample valid (no backpressure).
- fir_tlast_in  input  1  FIR marks channel NUM_CH-1 output.
- ch_data_out  output  NUM_CH*WIDTH  held decimated outputs.
- ch_valid_out  output  NUM_CH  one-cycle strobe per updated channel.
- overrun_out, stale_out, sync_err_out  output  1 each  sticky error flags.
- overrun_cnt_out, stale_cnt_out, sync_err_cnt_out  output  16 each  statistics counters.

## Operation
- Capture: per channel, a hold register and pending bit. A strobe loads hold and sets pending. A strobe while pending and not being consumed overwrites hold and sets overrun.
- Input FSM, states COLLECT, ISSUE:
  - COLLECT: skew counter starts on the first pending bit. When all bits are pending -> ISSUE, idx=0. When skew counter reaches SKEW_MAX with some bits missing -> ISSUE anyway. Missing channels reuse their last hold value, and stale is set.
  - ISSUE: drive hold[idx], tvalid=1, tlast=(idx==NUM_CH-1). On tvalid&&tready, clear pending[idx] and advance idx. After the last beat -> COLLECT and clear the skew counter.
- A strobe in the same cycle its channel is consumed becomes pending for the next frame. It is not an overrun.
- Output demux: out_idx increments on each fir_tvalid_in and wraps at NUM_CH-1. A per-frame decimation counter advances when out_idx wraps.
  - Beats in a frame whose decimation count is 0 update ch_data_out[out_idx] and pulse ch_valid_out[out_idx].
- Sync check: fir_tlast_in must equal (out_idx==NUM_CH-1). On mismatch:
  - set sync_err;
  - force out_idx=0 and the decimation counter to 0 on the next beat;
  - drop the mismatched sample.
- Reset values: all outputs 0, FSM COLLECT, all counters, pending bits and flags 0. Reset mid-frame abandons the frame. The FIR must be reset alongside this block.
- Arithmetic: no data modification. Counters are saturating at 16'hFFFF.

## Timing
- Strobe at cycle t: pending is visible at t+1. If this completes the frame, the FSM enters ISSUE at t+2 and fir_tvalid_out is high from t+2.
- With tready held high, a frame takes exactly NUM_CH consecutive beats.
- fir_tvalid_out and fir_tdata_out are registered and held stable until accepted. tvalid never drops without a handshake.
- Output path: fir_tvalid_in at cycle u -> ch_valid_out and ch_data_out updated at u+1.
- Flags are sticky until rst_in.

## Configuration
- MIC_FIR_SCHED_STATS_EN defined: the three 16-bit saturating counters increment once per overrun event, stale frame and sync error.
- Not defined: counter ports are tied to 0 and the counter logic is removed. Sticky flags remain in both builds.

## Structure
- Shared package mic_sched_pkg:
  - state enum (COLLECT, ISSUE);
  - default NUM_CH, WIDTH;
  - STAT_W=16.
- One sub-module, mic_frame_demux: output index, decimation counter, tlast sync check. The input FSM stays in the top.

## Test plan
- All three strobes in the same cycle, values 0x0100, 0x0200, 0x0300, tready=1 -> fir beats 0x0100, 0x0200, 0x0300 on consecutive cycles, tlast on the third. Stale, overrun and sync_err stay 0.
- Channel 2 strobes 70 cycles after channels 0 and 1, SKEW_MAX=64 -> frame issues at skew 64 with the old ch2 hold. stale=1, stale_cnt=1.
- Two strobes on channel 1 (0x1111 then 0x2222) before the frame completes -> 0x2222 issued, overrun=1, overrun_cnt=1.
- tready low for 5 cycles mid-frame -> tdata and tvalid stable throughout. No beat is lost or duplicated.
- Loopback FIR model (tdata echoed, 4-cycle latency, correct tlast), DECIM=2, 4 frames -> ch_valid_out pulses for frames 0 and 2 only, with matching data per channel.
- Inject fir_tlast_in on out_idx=1 -> sync_err=1, sample dropped, next beat routed to channel 0.
